// File: rtl/calc_keys_pkg.sv
// Shared key codes, entry FSM states and an elaboration helper for the
// keypad operand entry block.
package calc_keys_pkg;

   localparam int unsigned KEY_ENTER    = 11;
   localparam int unsigned KEY_CLEAR    = 12;
   localparam int unsigned KEY_SEL_BASE = 15;
   localparam int unsigned DIGIT_MAX    = 9;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      FULL    = 2'd1,
      PENDING = 2'd2
   } entry_state_e;

   // Largest value representable with the given number of decimal digits.
   function automatic logic [63:0] max_decimal(input int unsigned digits);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Accepts one keypad press after DEBOUNCE_CYCLES consecutive high samples
// and latches its code; re-arms only once the key has been seen released.
module key_debounce #(
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_code,
   input  logic             key_pressed,
   output logic             accept,
   output logic [KEY_W-1:0] key
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic             accept_q, accept_d;
   logic [KEY_W-1:0] key_q, key_d;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      accept_d = 1'b0;
      key_d    = key_q;
      if (!key_pressed) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else if (armed_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_W'(DEBOUNCE_CYCLES)) begin
            accept_d = 1'b1;
            key_d    = key_code;
            armed_d  = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         armed_q  <= 1'b1;
         accept_q <= 1'b0;
         key_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         accept_q <= accept_d;
         key_q    <= key_d;
      end
   end

   assign accept = accept_q;
   assign key    = key_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Builds decimal operands from debounced keypad presses and hands the whole
// operand set to the ALU through a valid/ready handshake.
module keypad_operand_entry
   import calc_keys_pkg::*;
#(
   parameter int DIGITS          = 2,
   parameter int NUM_OPERANDS    = 2,
   parameter int OP_W            = 32,
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [KEY_W-1:0]             key_code,
   input  logic                         key_pressed,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_OPERANDS*OP_W-1:0] operands,
   output logic [NUM_OPERANDS-1:0]      sel_led,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         key_dropped
);

   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int SEL_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;

   if (NUM_OPERANDS < 2 || NUM_OPERANDS > 4) begin : g_bad_num_operands
      $error("NUM_OPERANDS must be in 2..4");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   if ((max_decimal(DIGITS) >> OP_W) != 64'd0) begin : g_bad_op_w
      $error("10**DIGITS-1 does not fit in OP_W bits");
   end

   logic             accept;
   logic [KEY_W-1:0] key;

   key_debounce #(
      .KEY_W          (KEY_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_pressed(key_pressed),
      .accept     (accept),
      .key        (key)
   );

   entry_state_e            state_q, state_d;
   logic [OP_W-1:0]         opnd_q [NUM_OPERANDS];
   logic [OP_W-1:0]         opnd_d [NUM_OPERANDS];
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [NUM_OPERANDS-1:0] sel_led_q, sel_led_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    dropped_q, dropped_d;

   logic             is_digit, is_sel;
   logic [SEL_W-1:0] key_sel;

   always_comb begin
      is_digit = (key <= KEY_W'(DIGIT_MAX));
      is_sel   = (key >= KEY_W'(KEY_SEL_BASE - NUM_OPERANDS + 1)) &&
                 (key <= KEY_W'(KEY_SEL_BASE));
      key_sel  = SEL_W'(KEY_W'(KEY_SEL_BASE) - key);
   end

   always_comb begin
      state_d   = state_q;
      opnd_d    = opnd_q;
      sel_d     = sel_q;
      sel_led_d = sel_led_q;
      cnt_d     = cnt_q;
      dropped_d = 1'b0;
      case (state_q)
         PENDING: begin
            // Operands stay frozen; a press landing with the handshake is still dropped.
            dropped_d = accept;
            if (out_ready) begin
               for (int i = 0; i < NUM_OPERANDS; i++) begin
                  opnd_d[i] = '0;
               end
               cnt_d     = '0;
               sel_d     = '0;
               sel_led_d = NUM_OPERANDS'(1);
               state_d   = ENTRY;
            end
         end
         default: begin
            if (accept) begin
               if (is_digit) begin
                  if (state_q == FULL) begin
                     dropped_d = 1'b1;
                  end else begin
                     opnd_d[sel_q] = opnd_q[sel_q] * OP_W'(10) + OP_W'(key);
                     cnt_d         = cnt_q + 1'b1;
                     if (cnt_d == CNT_W'(DIGITS)) begin
                        state_d = FULL;
                     end
                  end
               end else if (key == KEY_W'(KEY_ENTER)) begin
                  state_d = PENDING;
               end else if (key == KEY_W'(KEY_CLEAR)) begin
                  opnd_d[sel_q] = '0;
                  cnt_d         = '0;
                  state_d       = ENTRY;
               end else if (is_sel) begin
                  sel_d           = key_sel;
                  sel_led_d       = NUM_OPERANDS'(1) << key_sel;
                  opnd_d[key_sel] = '0;
                  cnt_d           = '0;
                  state_d         = ENTRY;
               end
            end
         end
      endcase
   end

   // NOTE: the operand array is reset because its contents are visible outputs that must read 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ENTRY;
         for (int i = 0; i < NUM_OPERANDS; i++) begin
            opnd_q[i] <= '0;
         end
         sel_q     <= '0;
         sel_led_q <= '0;
         cnt_q     <= '0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opnd_q    <= opnd_d;
         sel_q     <= sel_d;
         sel_led_q <= sel_led_d;
         cnt_q     <= cnt_d;
         dropped_q <= dropped_d;
      end
   end

   for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_pack
      assign operands[i*OP_W +: OP_W] = opnd_q[i];
   end

   assign out_valid   = (state_q == PENDING);
   assign sel_led     = sel_led_q;
   assign digit_count = cnt_q;
   assign key_dropped = dropped_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry: a press-level behavioural model is
// compared every cycle, plus hand-computed literal checks along the way.
module tb_keypad_operand_entry;

   localparam int DIGITS          = 2;
   localparam int NUM_OPERANDS    = 2;
   localparam int OP_W            = 32;
   localparam int KEY_W           = 4;
   localparam int DEBOUNCE_CYCLES = 3;

   logic                         clk;
   logic                         rst;
   logic [KEY_W-1:0]             key_code;
   logic                         key_pressed;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_OPERANDS*OP_W-1:0] operands;
   logic [NUM_OPERANDS-1:0]      sel_led;
   logic [$clog2(DIGITS+1)-1:0]  digit_count;
   logic                         key_dropped;

   int vectors = 0;
   int errors  = 0;

   keypad_operand_entry #(
      .DIGITS         (DIGITS),
      .NUM_OPERANDS   (NUM_OPERANDS),
      .OP_W           (OP_W),
      .KEY_W          (KEY_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code),
      .key_pressed(key_pressed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .operands   (operands),
      .sel_led    (sel_led),
      .digit_count(digit_count),
      .key_dropped(key_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Model state: run length of the current press, whether a press was accepted
   // on the last edge, and the architectural contents seen at the outputs.
   typedef struct packed {
      int                                 run;
      bit                                 acc;
      logic [KEY_W-1:0]                   code;
      logic [NUM_OPERANDS-1:0][OP_W-1:0]  ops;
      int                                 sel;
      logic [NUM_OPERANDS-1:0]            led;
      int                                 cnt;
      bit                                 valid;
      bit                                 drop;
   } model_t;

   model_t m;

   function automatic model_t step(model_t cur, bit kp, logic [KEY_W-1:0] kc, bit rdy);
      model_t nxt;
      int     c;
      nxt      = cur;
      nxt.drop = 1'b0;
      c        = int'(cur.code);
      if (cur.valid) begin
         if (cur.acc) nxt.drop = 1'b1;
         if (rdy) begin
            nxt.valid = 1'b0;
            nxt.ops   = '0;
            nxt.cnt   = 0;
            nxt.sel   = 0;
            nxt.led   = NUM_OPERANDS'(1);
         end
      end else if (cur.acc) begin
         if (c <= 9) begin
            if (cur.cnt == DIGITS) begin
               nxt.drop = 1'b1;
            end else begin
               nxt.ops[cur.sel] = cur.ops[cur.sel] * OP_W'(10) + OP_W'(c);
               nxt.cnt          = cur.cnt + 1;
            end
         end else if (c == 11) begin
            nxt.valid = 1'b1;
         end else if (c == 12) begin
            nxt.ops[cur.sel] = '0;
            nxt.cnt          = 0;
         end else if (c >= 16 - NUM_OPERANDS && c <= 15) begin
            nxt.sel          = 15 - c;
            nxt.led          = NUM_OPERANDS'(1) << (15 - c);
            nxt.ops[15 - c]  = '0;
            nxt.cnt          = 0;
         end
      end
      if (kp) begin
         nxt.run  = cur.run + 1;
         nxt.acc  = (nxt.run == DEBOUNCE_CYCLES);
         nxt.code = kc;
      end else begin
         nxt.run = 0;
         nxt.acc = 1'b0;
      end
      return nxt;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= step(m, key_pressed, key_code, out_ready);
   end

   always @(negedge clk) begin
      check("cyc_valid",    64'(out_valid),   64'(m.valid));
      check("cyc_operands", 64'(operands),    64'(m.ops));
      check("cyc_sel_led",  64'(sel_led),     64'(m.led));
      check("cyc_count",    64'(digit_count), 64'(m.cnt));
      check("cyc_dropped",  64'(key_dropped), 64'(m.drop));
   end

   // Call at a negedge; returns the number of key_dropped pulses seen.
   task automatic press(input int code, input int hold, input int rel, output int drops);
      drops       = 0;
      key_code    = KEY_W'(code);
      key_pressed = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         if (key_dropped) drops++;
      end
      key_pressed = 1'b0;
      repeat (rel) begin
         @(negedge clk);
         if (key_dropped) drops++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d;
      rst         = 1'b1;
      key_pressed = 1'b0;
      key_code    = '0;
      out_ready   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid",    64'(out_valid),   64'd0);
      check("rst_operands", 64'(operands),    64'd0);
      check("rst_sel_led",  64'(sel_led),     64'd0);
      check("rst_count",    64'(digit_count), 64'd0);
      check("rst_dropped",  64'(key_dropped), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      press(4, 5, 2, d);
      press(2, 5, 2, d);
      check("op0_42",   64'(operands[31:0]), 64'd42);
      check("cnt_full", 64'(digit_count),    64'd2);
      check("led_none", 64'(sel_led),        64'd0);

      press(7, 5, 2, d);
      check("full_drop",    64'(d),              64'd1);
      check("full_op0_42",  64'(operands[31:0]), 64'd42);

      press(13, 5, 2, d);
      check("ignored_nodrop", 64'(d),              64'd0);
      check("ignored_op0",    64'(operands[31:0]), 64'd42);

      press(14, 5, 2, d);
      press(9, 5, 2, d);
      check("sel1_led", 64'(sel_led),          64'b10);
      check("op1_9",    64'(operands[63:32]),  64'd9);
      check("op1_cnt",  64'(digit_count),      64'd1);

      key_code    = KEY_W'(11);
      key_pressed = 1'b1;
      repeat (3) @(negedge clk);
      check("enter_not_yet", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("enter_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      key_pressed = 1'b0;
      repeat (2) @(negedge clk);

      repeat (10) @(negedge clk);
      check("pend_valid_held", 64'(out_valid), 64'd1);
      check("pend_operands",   64'(operands),  {32'd9, 32'd42});

      press(5, 5, 2, d);
      check("pend_drop",     64'(d),        64'd1);
      check("pend_operands2", 64'(operands), {32'd9, 32'd42});

      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_valid",    64'(out_valid),   64'd0);
      check("hs_operands", 64'(operands),    64'd0);
      check("hs_sel_led",  64'(sel_led),     64'b01);
      check("hs_count",    64'(digit_count), 64'd0);

      press(3, 50, 2, d);
      check("long_nodrop", 64'(d),              64'd0);
      check("long_op0",    64'(operands[31:0]), 64'd3);
      check("long_cnt",    64'(digit_count),    64'd1);

      press(8, DEBOUNCE_CYCLES - 1, 2, d);
      check("short_op0", 64'(operands[31:0]), 64'd3);
      check("short_cnt", 64'(digit_count),    64'd1);

      press(15, 5, 2, d);
      check("reselect_op0", 64'(operands[31:0]), 64'd0);
      check("reselect_led", 64'(sel_led),        64'b01);
      press(4, 5, 2, d);
      check("pre_rst_op0", 64'(operands[31:0]), 64'd4);

      key_code    = KEY_W'(6);
      key_pressed = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_valid",    64'(out_valid),   64'd0);
      check("arst_operands", 64'(operands),    64'd0);
      check("arst_sel_led",  64'(sel_led),     64'd0);
      check("arst_count",    64'(digit_count), 64'd0);
      check("arst_dropped",  64'(key_dropped), 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("held_not_yet", 64'(digit_count), 64'd0);
      @(negedge clk);
      check("held_op0", 64'(operands[31:0]), 64'd6);
      check("held_cnt", 64'(digit_count),    64'd1);
      repeat (10) @(negedge clk);
      check("held_once", 64'(digit_count), 64'd1);
      key_pressed = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
- Converts debounced keypad presses into decimal multi-digit operands for the stopwatch-calculator datapath.
- Supports NUM_OPERANDS operand registers. Select keys choose the operand, a clear key resets it, and an enter key hands all operands to the ALU through a valid/ready handshake.
- Sits between the keypad scanner (key code plus level press flag) and the calculator ALU and display.

Parameters:
- DIGITS, 2, max decimal digits per operand; extra digits are ignored.
- NUM_OPERANDS, 2, number of operand registers (2..4).
- OP_W, 32, operand width; 10^DIGITS-1 must fit in OP_W (elaboration check).
- KEY_W, 4, key code width.
- DEBOUNCE_CYCLES, 3, consecutive high cycles of key_pressed required to accept a press (>=1).

Ports:
- clk, in, 1, system clock, all logic on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- key_code, in, KEY_W, keypad code, sampled when the press is accepted.
- key_pressed, in, 1, level press flag from the scanner.
- out_valid, out, 1, operand set is pending for the ALU.
- out_ready, in, 1, ALU accepts the operand set.
- operands, out, NUM_OPERANDS*OP_W, operand i occupies bits [i*OP_W +: OP_W].
- sel_led, out, NUM_OPERANDS, one-hot indicator of the selected operand; all zero until the first select key.
- digit_count, out, $clog2(DIGITS+1), digits entered into the selected operand.
- key_dropped, out, 1, one-cycle pulse when an accepted press is discarded.

Behaviour:
- Reset (async, rst=1): all outputs are 0. sel index = 0, debounce counter = 0, armed = 1, state = ENTRY.
- Debounce (sub-module):
  - The counter increments while key_pressed=1 and armed=1, and clears when key_pressed=0.
  - The cycle the count reaches DEBOUNCE_CYCLES, it emits a one-cycle accept pulse, latches key_code, and sets armed=0.
  - armed returns to 1 only after key_pressed has been sampled 0.
  - Result: exactly one accept per press, however long the key is held.
  - Accept latency: DEBOUNCE_CYCLES cycles after the first sampled high. Register updates land on the following edge.
- Key decode (codes in the shared package):
  - Digits 0..9.
  - KEY_ENTER = 11.
  - KEY_CLEAR = 12.
  - Select codes 15 down to 15-NUM_OPERANDS+1 select operand 0, 1, ...
  - Any other code: ignored, no drop pulse.
- FSM states:
  - ENTRY: digit_count < DIGITS.
  - FULL: digit_count == DIGITS.
  - PENDING: out_valid = 1.
- Digit in ENTRY: sel operand <= sel operand*10 + digit; digit_count += 1. Go to FULL when the count reaches DIGITS.
- Digit in FULL: operand unchanged; key_dropped pulses.
- Select key i (ENTRY or FULL):
  - sel index <= i; sel_led <= one-hot(i).
  - operand i <= 0; digit_count <= 0; state -> ENTRY.
  - Selecting the already-selected operand also clears it.
- KEY_CLEAR (ENTRY or FULL): selected operand <= 0; digit_count <= 0; state -> ENTRY. sel_led is unchanged.
- KEY_ENTER (ENTRY or FULL): out_valid <= 1; state -> PENDING. Operands are frozen.
- PENDING:
  - Every accepted press pulses key_dropped and changes nothing else.
  - When out_valid & out_ready on an edge: out_valid <= 0, all operands <= 0, digit_count <= 0, sel index <= 0, sel_led <= one-hot(0), state -> ENTRY.
  - An accept in the same cycle as the handshake is dropped and pulses key_dropped.
- Handshake rules:
  - out_valid never deasserts without out_ready.
  - operands are stable while out_valid = 1.
  - out_ready while out_valid = 0 has no effect.
- Reset mid-press: the debounce counter clears. A key still held after reset is accepted once after DEBOUNCE_CYCLES, because armed resets to 1.
- Arithmetic: the multiply-by-10 is computed at OP_W width. No overflow is possible given the DIGITS/OP_W check.

Decomposition:
- Package calc_keys_pkg holds:
  - KEY_ENTER, KEY_CLEAR, KEY_SEL_BASE=15;
  - the digit range limit (9);
  - the FSM state enum typedef (ENTRY, FULL, PENDING).
- Sub-module key_debounce (params KEY_W, DEBOUNCE_CYCLES) owns the counter, armed flag and code latch, and outputs accept and key.

Test Plan:
- Reset, then press 4, 2 (each held 5 cycles, released 2) → operand0 = 42, digit_count = 2, sel_led = 00, state FULL.
- From the previous state, press 7 → operand0 stays 42, key_dropped pulses once.
- Press 14, 9, 11 → sel_led = 10, operand1 = 9. out_valid rises 1 cycle after the enter accept. With out_ready held 0 for 10 cycles, operands stay {9,42}.
- While PENDING, press 5, then assert out_ready → key_dropped pulses for the 5. After the handshake: out_valid = 0, operands = 0, sel_led = 01.
- Hold key 3 high for 50 cycles → exactly one accept, operand = 3. A high pulse shorter than DEBOUNCE_CYCLES produces no accept.
- Assert rst asynchronously mid-entry (operand0 = 4) between clock edges → all outputs 0 immediately. Key still held → accepted once after DEBOUNCE_CYCLES.
